// File: rtl/mips_exec_mem_if.sv
// mips_exec_mem_if: instruction, operand, decode, ALU and data-memory signals of the exec/mem stage
interface mips_exec_mem_if;
  logic        we;
  logic        re;
  logic [31:0] ins_mem;
  logic [31:0] read_data1;
  logic [31:0] read_data2;
  logic [4:0]  read_register1;
  logic [4:0]  read_register2;
  logic [4:0]  write_register;
  logic [31:0] ALU_result;
  logic        zero;
  logic [31:0] data_mem_out;
  modport master (
    output we, re, ins_mem, read_data1, read_data2,
    input  read_register1, read_register2, write_register, ALU_result, zero, data_mem_out
  );
  modport slave (
    input  we, re, ins_mem, read_data1, read_data2,
    output read_register1, read_register2, write_register, ALU_result, zero, data_mem_out
  );
endinterface

// File: rtl/mips_exec_mem_stage.sv
// mips_exec_mem_stage: single-cycle MIPS decode, ALU and word-addressed data memory
module mips_exec_mem_stage #(
  parameter int MEM_DEPTH  = 64,
  parameter int MEM_ADDR_W = 6
) (
  input logic clk,
  input logic rst,
  mips_exec_mem_if.slave bus
);
  logic [5:0]            opcode;
  logic [5:0]            funct;
  logic [4:0]            shamt;
  logic [31:0]           rd1;
  logic [31:0]           rd2;
  logic [31:0]           imm_s;
  logic [31:0]           imm_z;
  logic [31:0]           alu;
  logic [MEM_ADDR_W-1:0] idx;
  logic [31:0]           mem_q [MEM_DEPTH];
  logic [31:0]           dout_q;
  assign opcode = bus.ins_mem[31:26];
  assign funct  = bus.ins_mem[5:0];
  assign shamt  = bus.ins_mem[10:6];
  assign rd1    = bus.read_data1;
  assign rd2    = bus.read_data2;
  assign imm_s  = {{16{bus.ins_mem[15]}}, bus.ins_mem[15:0]};
  assign imm_z  = {16'h0, bus.ins_mem[15:0]};
  assign bus.read_register1 = bus.ins_mem[25:21];
  assign bus.read_register2 = bus.ins_mem[20:16];
  assign bus.write_register = (opcode == 6'h00) ? bus.ins_mem[15:11] : bus.ins_mem[20:16];
  always_comb begin
    alu = '0;
    if (opcode == 6'h00) begin
      case (funct)
        6'h20, 6'h21: alu = rd1 + rd2;
        6'h22, 6'h23: alu = rd1 - rd2;
        6'h24:        alu = rd1 & rd2;
        6'h25:        alu = rd1 | rd2;
        6'h26:        alu = rd1 ^ rd2;
        6'h27:        alu = ~(rd1 | rd2);
        6'h2A:        alu = {31'h0, $signed(rd1) < $signed(rd2)};
        6'h2B:        alu = {31'h0, rd1 < rd2};
        6'h00:        alu = rd2 << shamt;
        6'h02:        alu = rd2 >> shamt;
        6'h03:        alu = $unsigned($signed(rd2) >>> shamt);
        default:      alu = '0;
      endcase
    end else begin
      case (opcode)
        6'h23, 6'h2B, 6'h08, 6'h09: alu = rd1 + imm_s;
        6'h0C:   alu = rd1 & imm_z;
        6'h0D:   alu = rd1 | imm_z;
        6'h0A:   alu = {31'h0, $signed(rd1) < $signed(imm_s)};
        6'h0F:   alu = {bus.ins_mem[15:0], 16'h0};
        default: alu = '0;
      endcase
    end
  end
  assign bus.ALU_result   = alu;
  assign bus.zero         = (alu == '0);
  assign idx              = alu[MEM_ADDR_W-1:0];
  assign bus.data_mem_out = dout_q;
  // write has priority over read; a read returns the word as it was before this edge
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
      dout_q <= '0;
    end else if (bus.we) begin
      mem_q[idx] <= rd2;
    end else if (bus.re) begin
      dout_q <= mem_q[idx];
    end
  end
endmodule

// File: tb/tb_mips_exec_mem_stage.sv
// tb_mips_exec_mem_stage: table-driven ALU/decode vectors plus directed memory sequences
module tb_mips_exec_mem_stage;
  logic clk = 0;
  logic rst;
  int   n_chk = 0;
  int   n_fail = 0;
  mips_exec_mem_if bus ();
  mips_exec_mem_stage dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    string       name;
    logic [31:0] ins;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [4:0]  rr1;
    logic [4:0]  rr2;
    logic [4:0]  wr;
    logic [31:0] alu;
    logic        z;
  } vec_t;
  vec_t vecs [18];
  function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd, sh, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction
  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [31:0] ins, input logic [31:0] d1, input logic [31:0] d2, input logic w, input logic r);
    bus.ins_mem = ins;
    bus.read_data1 = d1;
    bus.read_data2 = d2;
    bus.we = w;
    bus.re = r;
  endtask
  initial begin
    vecs[0]  = '{"add",      32'h012A4020, 32'd5, 32'd7, 5'd9, 5'd10, 5'd8, 32'd12, 1'b0};
    vecs[1]  = '{"sub_neg",  rtype(1,2,3,0,6'h22), 32'd3, 32'd5, 5'd1, 5'd2, 5'd3, 32'hFFFFFFFE, 1'b0};
    vecs[2]  = '{"slt",      rtype(4,5,6,0,6'h2A), 32'hFFFFFFFF, 32'd1, 5'd4, 5'd5, 5'd6, 32'd1, 1'b0};
    vecs[3]  = '{"sltu",     rtype(4,5,6,0,6'h2B), 32'hFFFFFFFF, 32'd1, 5'd4, 5'd5, 5'd6, 32'd0, 1'b1};
    vecs[4]  = '{"sub_zero", rtype(7,8,9,0,6'h23), 32'd7, 32'd7, 5'd7, 5'd8, 5'd9, 32'd0, 1'b1};
    vecs[5]  = '{"and",      rtype(1,2,31,0,6'h24), 32'h0000F0F0, 32'h0000FF00, 5'd1, 5'd2, 5'd31, 32'h0000F000, 1'b0};
    vecs[6]  = '{"nor",      rtype(0,0,1,0,6'h27), 32'h0, 32'h0, 5'd0, 5'd0, 5'd1, 32'hFFFFFFFF, 1'b0};
    vecs[7]  = '{"sra",      rtype(0,3,2,4,6'h03), 32'h0, 32'h80000000, 5'd0, 5'd3, 5'd2, 32'hF8000000, 1'b0};
    vecs[8]  = '{"srl",      rtype(0,3,2,4,6'h02), 32'h0, 32'h80000000, 5'd0, 5'd3, 5'd2, 32'h08000000, 1'b0};
    vecs[9]  = '{"sll",      rtype(0,3,2,8,6'h00), 32'h0, 32'h1, 5'd0, 5'd3, 5'd2, 32'h00000100, 1'b0};
    vecs[10] = '{"bad_fn",   rtype(1,1,1,0,6'h3F), 32'd5, 32'd5, 5'd1, 5'd1, 5'd1, 32'd0, 1'b1};
    vecs[11] = '{"addi",     itype(6'h08,1,2,16'hFFFF), 32'd10, 32'd0, 5'd1, 5'd2, 5'd2, 32'd9, 1'b0};
    vecs[12] = '{"ori",      itype(6'h0D,3,4,16'h8000), 32'h1, 32'h0, 5'd3, 5'd4, 5'd4, 32'h00008001, 1'b0};
    vecs[13] = '{"andi",     itype(6'h0C,3,4,16'hFFFF), 32'hFFFF0F0F, 32'h0, 5'd3, 5'd4, 5'd4, 32'h00000F0F, 1'b0};
    vecs[14] = '{"slti",     itype(6'h0A,5,6,16'hFFFF), 32'hFFFFFFFE, 32'h0, 5'd5, 5'd6, 5'd6, 32'd1, 1'b0};
    vecs[15] = '{"lui",      itype(6'h0F,0,7,16'h1234), 32'h5, 32'h0, 5'd0, 5'd7, 5'd7, 32'h12340000, 1'b0};
    vecs[16] = '{"bad_op",   itype(6'h3F,1,2,16'h0001), 32'h5, 32'h5, 5'd1, 5'd2, 5'd2, 32'd0, 1'b1};
    vecs[17] = '{"xor",      rtype(10,11,12,0,6'h26), 32'h000000FF, 32'h0000000F, 5'd10, 5'd11, 5'd12, 32'h000000F0, 1'b0};
    rst = 1;
    drive(32'h0, 32'h0, 32'hAAAAAAAA, 1'b1, 1'b0);
    tick();
    tick();
    chk("reset_dout", bus.data_mem_out, 32'h0);
    rst = 0;
    foreach (vecs[i]) begin
      drive(vecs[i].ins, vecs[i].rd1, vecs[i].rd2, 1'b0, 1'b0);
      #1;
      chk({vecs[i].name, "_rr1"}, 32'(bus.read_register1), 32'(vecs[i].rr1));
      chk({vecs[i].name, "_rr2"}, 32'(bus.read_register2), 32'(vecs[i].rr2));
      chk({vecs[i].name, "_wr"}, 32'(bus.write_register), 32'(vecs[i].wr));
      chk({vecs[i].name, "_alu"}, bus.ALU_result, vecs[i].alu);
      chk({vecs[i].name, "_zero"}, 32'(bus.zero), 32'(vecs[i].z));
    end
    drive(itype(6'h23,0,0,16'd0), 32'h0, 32'h0, 1'b0, 1'b1);
    tick();
    chk("rd0_after_rst", bus.data_mem_out, 32'h0);
    drive(itype(6'h23,0,0,16'd6), 32'h0, 32'h0, 1'b0, 1'b1);
    tick();
    chk("rd6_after_rst", bus.data_mem_out, 32'h0);
    drive(itype(6'h23,0,0,16'd63), 32'h0, 32'h0, 1'b0, 1'b1);
    tick();
    chk("rd63_after_rst", bus.data_mem_out, 32'h0);
    drive(32'hAD2A0004, 32'd2, 32'hDEADBEEF, 1'b1, 1'b0);
    #1;
    chk("sw_alu", bus.ALU_result, 32'd6);
    chk("sw_wr", 32'(bus.write_register), 32'd10);
    tick();
    chk("sw_dout_hold", bus.data_mem_out, 32'h0);
    drive(32'h8D2A0004, 32'd2, 32'h0, 1'b0, 1'b1);
    tick();
    chk("lw6", bus.data_mem_out, 32'hDEADBEEF);
    drive(itype(6'h23,0,0,16'd0), 32'h0, 32'h0, 1'b0, 1'b1);
    tick();
    chk("lw0", bus.data_mem_out, 32'h0);
    drive(itype(6'h23,9,10,16'hFFFC), 32'd10, 32'h0, 1'b0, 1'b1);
    #1;
    chk("lw_neg_alu", bus.ALU_result, 32'd6);
    tick();
    chk("lw_neg_imm", bus.data_mem_out, 32'hDEADBEEF);
    drive(itype(6'h23,0,0,16'd0), 32'h0, 32'h0, 1'b0, 1'b1);
    tick();
    drive(itype(6'h23,9,10,16'd4), 32'd66, 32'h0, 1'b0, 1'b1);
    #1;
    chk("wrap_alu", bus.ALU_result, 32'd70);
    tick();
    chk("lw_wrap", bus.data_mem_out, 32'hDEADBEEF);
    drive(itype(6'h2B,0,0,16'd6), 32'h0, 32'h12345678, 1'b1, 1'b1);
    tick();
    chk("we_re_hold", bus.data_mem_out, 32'hDEADBEEF);
    drive(itype(6'h23,0,0,16'd0), 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    chk("idle_hold", bus.data_mem_out, 32'hDEADBEEF);
    drive(itype(6'h23,0,0,16'd6), 32'h0, 32'h0, 1'b0, 1'b1);
    tick();
    chk("rd_new6", bus.data_mem_out, 32'h12345678);
    rst = 1;
    drive(itype(6'h2B,0,0,16'd5), 32'h0, 32'hCAFEF00D, 1'b1, 1'b1);
    tick();
    chk("mid_rst_dout", bus.data_mem_out, 32'h0);
    rst = 0;
    drive(itype(6'h23,0,0,16'd6), 32'h0, 32'h0, 1'b0, 1'b1);
    tick();
    chk("rd6_cleared", bus.data_mem_out, 32'h0);
    drive(itype(6'h23,0,0,16'd5), 32'h0, 32'h0, 1'b0, 1'b1);
    tick();
    chk("rd5_discarded", bus.data_mem_out, 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
